// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the pipelined multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_op_t;

  localparam int MULT_MIN_STAGES = 2;

  // Operand A is treated as signed for MULH and MULHSU.
  function automatic logic op_sign_a(input mult_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // Operand B is treated as signed for MULH only.
  function automatic logic op_sign_b(input mult_op_t op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/mult_pipe_reg.sv
// rtl/mult_pipe_reg.sv - one pipeline stage: data register plus valid bit
module mult_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Shift on enable; data only loads for valid entries so outputs stay stable across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mult_unit_pipelined.sv
// rtl/mult_unit_pipelined.sv - fully pipelined multiplier with tag passthrough and four result modes
module mult_unit_pipelined
  import mult_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int STAGES   = 3,
  parameter int TAG_LEN  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_a,
  input  logic [DATA_LEN-1:0] in_b,
  input  logic [1:0]          in_op,
  input  logic [TAG_LEN-1:0]  in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_result,
  output logic [TAG_LEN-1:0]  out_tag
);

  localparam int XW  = DATA_LEN + 1;          // extended operand width
  localparam int PW  = 2 * DATA_LEN + 2;      // full signed product width
  localparam int S1W = 2 + TAG_LEN + 2 * XW;  // stage 1 payload
  localparam int MW  = 2 + TAG_LEN + PW;      // product-stage payload
  localparam int OW  = TAG_LEN + DATA_LEN;    // output payload

  if (STAGES < MULT_MIN_STAGES || DATA_LEN < 2) begin : g_bad_params
    $error("mult_unit_pipelined: STAGES must be >= 2 and DATA_LEN must be >= 2");
  end

  // One global enable: the whole pipe moves when the output slot is free or being drained.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Stage 1: extend operands according to the signedness of the requested mode.
  mult_op_t          in_op_e;
  logic [XW-1:0]     a_ext;
  logic [XW-1:0]     b_ext;
  logic              s1_valid;
  logic [S1W-1:0]    s1_data;

  assign in_op_e = mult_op_t'(in_op);
  assign a_ext   = {op_sign_a(in_op_e) & in_a[DATA_LEN-1], in_a};
  assign b_ext   = {op_sign_b(in_op_e) & in_b[DATA_LEN-1], in_b};

  mult_pipe_reg #(.WIDTH(S1W)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .en        (advance),
    .in_valid  (in_valid),
    .in_data   ({in_op, in_tag, a_ext, b_ext}),
    .out_valid (s1_valid),
    .out_data  (s1_data)
  );

  // Product between stage 1 and the next register; sign-extending both
  // operands to PW bits makes the truncated PW-bit product exact.
  logic [1:0]        s1_op;
  logic [TAG_LEN-1:0] s1_tag;
  logic [XW-1:0]     s1_a;
  logic [XW-1:0]     s1_b;
  logic [PW-1:0]     a_wide;
  logic [PW-1:0]     b_wide;
  logic [PW-1:0]     prod;
  logic [MW-1:0]     prod_data;

  assign s1_op     = s1_data[S1W-1 -: 2];
  assign s1_tag    = s1_data[2*XW +: TAG_LEN];
  assign s1_a      = s1_data[XW +: XW];
  assign s1_b      = s1_data[0 +: XW];
  assign a_wide    = {{(PW-XW){s1_a[XW-1]}}, s1_a};
  assign b_wide    = {{(PW-XW){s1_b[XW-1]}}, s1_b};
  assign prod      = a_wide * b_wide;
  assign prod_data = {s1_op, s1_tag, prod};

  // Retiming registers for the product (none when STAGES is 2).
  logic [MW-1:0] sel_data;
  logic          sel_valid;

  if (STAGES == 2) begin : g_no_retime
    assign sel_data  = prod_data;
    assign sel_valid = s1_valid;
  end else begin : g_retime
    logic [MW-1:0] rt_data  [STAGES-2];
    logic          rt_valid [STAGES-2];

    for (genvar i = 0; i < STAGES - 2; i++) begin : g_stage
      if (i == 0) begin : g_first
        mult_pipe_reg #(.WIDTH(MW)) u_rt (
          .clk       (clk),
          .reset     (reset),
          .en        (advance),
          .in_valid  (s1_valid),
          .in_data   (prod_data),
          .out_valid (rt_valid[i]),
          .out_data  (rt_data[i])
        );
      end else begin : g_next
        mult_pipe_reg #(.WIDTH(MW)) u_rt (
          .clk       (clk),
          .reset     (reset),
          .en        (advance),
          .in_valid  (rt_valid[i-1]),
          .in_data   (rt_data[i-1]),
          .out_valid (rt_valid[i]),
          .out_data  (rt_data[i])
        );
      end
    end

    assign sel_data  = rt_data[STAGES-3];
    assign sel_valid = rt_valid[STAGES-3];
  end

  // Final stage: pick the low or high product word.
  mult_op_t          sel_op;
  logic [TAG_LEN-1:0] sel_tag;
  logic [PW-1:0]     sel_prod;
  logic [DATA_LEN-1:0] sel_word;
  logic [OW-1:0]     fin_data;
  logic              unused_prod_hi;

  assign sel_op         = mult_op_t'(sel_data[MW-1 -: 2]);
  assign sel_tag        = sel_data[PW +: TAG_LEN];
  assign sel_prod       = sel_data[PW-1:0];
  assign sel_word       = (sel_op == MUL) ? sel_prod[DATA_LEN-1:0]
                                          : sel_prod[2*DATA_LEN-1:DATA_LEN];
  assign unused_prod_hi = ^sel_prod[PW-1:2*DATA_LEN];

  mult_pipe_reg #(.WIDTH(OW)) u_final (
    .clk       (clk),
    .reset     (reset),
    .en        (advance),
    .in_valid  (sel_valid),
    .in_data   ({sel_tag, sel_word}),
    .out_valid (out_valid),
    .out_data  (fin_data)
  );

  assign out_tag    = fin_data[DATA_LEN +: TAG_LEN];
  assign out_result = fin_data[DATA_LEN-1:0];

endmodule

// File: tb/tb_mult_unit_pipelined.sv
// tb/tb_mult_unit_pipelined.sv - scoreboard bench for the pipelined multiplier
module tb_mult_unit_pipelined;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: DATA_LEN 32, STAGES 3
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [31:0] m_in_a, m_in_b, m_out_result;
  logic [1:0]  m_in_op;
  logic [3:0]  m_in_tag, m_out_tag;

  // sweep instances: DATA_LEN 8, STAGES 2 and 5
  logic        s_in_valid, s_out_ready;
  logic [7:0]  s_in_a, s_in_b;
  logic [1:0]  s_in_op;
  logic [3:0]  s_in_tag;
  logic        s2_in_ready, s2_out_valid, s5_in_ready, s5_out_valid;
  logic [7:0]  s2_out_result, s5_out_result;
  logic [3:0]  s2_out_tag, s5_out_tag;

  mult_unit_pipelined #(.DATA_LEN(32), .STAGES(3), .TAG_LEN(4)) dut (
    .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b), .in_op(m_in_op), .in_tag(m_in_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_result(m_out_result), .out_tag(m_out_tag));

  mult_unit_pipelined #(.DATA_LEN(8), .STAGES(2), .TAG_LEN(4)) dut_s2 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s2_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_tag(s_in_tag),
    .out_valid(s2_out_valid), .out_ready(s_out_ready),
    .out_result(s2_out_result), .out_tag(s2_out_tag));

  mult_unit_pipelined #(.DATA_LEN(8), .STAGES(5), .TAG_LEN(4)) dut_s5 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s5_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_tag(s_in_tag),
    .out_valid(s5_out_valid), .out_ready(s_out_ready),
    .out_result(s5_out_result), .out_tag(s5_out_tag));

  sb_t q_m[$];
  sb_t q_2[$];
  sb_t q_5[$];
  bit  bp_mode = 1'b0;
  bit  bp_chk  = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_result = '0;
  logic [3:0]  prev_tag = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Arithmetic reference: operands interpreted per mode, exact product, word selected.
  function automatic logic [31:0] ref_mul(input int d, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] op);
    logic [31:0]        mask;
    logic signed [67:0] ax, bx, p;
    logic [67:0]        q;
    mask = (d >= 32) ? 32'hFFFF_FFFF : ((32'd1 << d) - 32'd1);
    ax = $signed({36'd0, a & mask});
    bx = $signed({36'd0, b & mask});
    if ((op == 2'd1 || op == 2'd2) && a[d-1]) ax = ax - (68'sd1 <<< d);
    if (op == 2'd1 && b[d-1]) bx = bx - (68'sd1 <<< d);
    p = ax * bx;
    q = p;
    if (op != 2'd0) q = q >> d;
    return q[31:0] & mask;
  endfunction

  // Output monitors and handshake-property checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (bp_chk) begin
        check("in_ready_rule", m_in_ready, !(m_out_valid && !m_out_ready));
        if (prev_stall) begin
          check("hold_valid", m_out_valid, 1);
          check("hold_result", m_out_result, prev_result);
          check("hold_tag", m_out_tag, prev_tag);
        end
      end
      if (m_out_valid && m_out_ready) begin
        if (q_m.size() == 0) check("m_unexpected_out", 1, 0);
        else begin
          check("m_result", m_out_result, q_m[0].res);
          check("m_tag", m_out_tag, q_m[0].tag);
          if (q_m[0].lat) check("m_latency", cyc - q_m[0].cyc, 3);
          void'(q_m.pop_front());
        end
      end
      if (s2_out_valid && s_out_ready) begin
        if (q_2.size() == 0) check("s2_unexpected_out", 1, 0);
        else begin
          check("s2_result", s2_out_result, q_2[0].res);
          check("s2_tag", s2_out_tag, q_2[0].tag);
          check("s2_latency", cyc - q_2[0].cyc, 2);
          void'(q_2.pop_front());
        end
      end
      if (s5_out_valid && s_out_ready) begin
        if (q_5.size() == 0) check("s5_unexpected_out", 1, 0);
        else begin
          check("s5_result", s5_out_result, q_5[0].res);
          check("s5_tag", s5_out_tag, q_5[0].tag);
          check("s5_latency", cyc - q_5[0].cyc, 5);
          void'(q_5.pop_front());
        end
      end
      prev_stall  <= m_out_valid && !m_out_ready;
      prev_result <= m_out_result;
      prev_tag    <= m_out_tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) m_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [3:0] tag, input logic [31:0] exp, input bit lat);
    int guard = 0;
    tick();
    m_in_valid = 1'b1;
    m_in_a = a;
    m_in_b = b;
    m_in_op = op;
    m_in_tag = tag;
    #1;
    while (!m_in_ready && guard < 100) begin
      tick();
      #1;
      guard++;
    end
    if (!m_in_ready) check("send_timeout", 0, 1);
    else if (!reset) q_m.push_back('{res: exp, tag: tag, cyc: cyc, lat: lat});
  endtask

  task automatic idle();
    tick();
    m_in_valid = 1'b0;
    s_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_m.size() != 0 || q_2.size() != 0 || q_5.size() != 0) && n < 300) begin
      idle();
      n++;
    end
    check("drain_m", q_m.size(), 0);
    check("drain_s", q_2.size() + q_5.size(), 0);
  endtask

  initial begin
    logic [31:0] exp2 [4];
    logic [31:0] exp3 [4];
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    exp2 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    exp3 = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000};

    reset = 1'b1;
    m_in_valid = 1'b1;
    m_in_a = 32'h1234_5678;
    m_in_b = 32'h9ABC_DEF0;
    m_in_op = 2'd0;
    m_in_tag = 4'h5;
    m_out_ready = 1'b1;
    s_in_valid = 1'b0;
    s_in_a = '0;
    s_in_b = '0;
    s_in_op = 2'd2;
    s_in_tag = '0;
    s_out_ready = 1'b1;

    // reset held with an operation offered
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", m_out_valid, 0);
      check("rst_result", m_out_result, 0);
      check("rst_tag", m_out_tag, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_valid", m_out_valid, 0);
    check("post_rst_result", m_out_result, 0);
    check("post_rst_tag", m_out_tag, 0);

    // all-ones times two, four modes back-to-back
    for (int i = 0; i < 4; i++)
      send(32'hFFFF_FFFF, 32'd2, 2'(i), 4'(i + 1), exp2[i], 1'b1);
    idle();
    drain();

    // most-negative squared
    for (int i = 0; i < 4; i++)
      send(32'h8000_0000, 32'h8000_0000, 2'(i), 4'(i + 5), exp3[i], 1'b1);
    idle();
    drain();

    // random stream under random backpressure
    bp_mode = 1'b1;
    bp_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rop = 2'($urandom_range(0, 3));
      send(ra, rb, rop, 4'(i), ref_mul(32, ra, rb, rop), 1'b0);
    end
    idle();
    drain();
    bp_chk = 1'b0;
    bp_mode = 1'b0;
    m_out_ready = 1'b1;
    idle();

    // reset arrives while the pipe is filling
    send(32'd3, 32'd5, 2'd0, 4'hA, 32'd15, 1'b1);
    send(32'd7, 32'd9, 2'd0, 4'hB, 32'd63, 1'b1);
    tick();
    reset = 1'b1;
    m_in_valid = 1'b1;
    m_in_a = 32'd11;
    m_in_b = 32'd13;
    m_in_tag = 4'hC;
    q_m.delete();
    tick();
    m_in_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_valid", m_out_valid, 0);
    end
    send(32'hFFFF_FFFD, 32'd4, 2'd3, 4'hD, 32'd3, 1'b1);
    idle();
    drain();

    // exhaustive MULHSU sweep on the 8-bit instances
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        @(posedge clk);
        #1;
        s_in_valid = 1'b1;
        s_in_a = 8'(a);
        s_in_b = 8'(b);
        s_in_op = 2'd2;
        s_in_tag = 4'(a + b);
        #1;
        if (!(s2_in_ready && s5_in_ready)) check("sweep_ready", 0, 1);
        q_2.push_back('{res: ref_mul(8, 32'(a), 32'(b), 2'd2), tag: 4'(a + b), cyc: cyc, lat: 1'b1});
        q_5.push_back('{res: ref_mul(8, 32'(a), 32'(b), 2'd2), tag: 4'(a + b), cyc: cyc, lat: 1'b1});
      end
    end
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
